// File: rtl/grain_ctrl.sv
// grain_ctrl: control FSM that loads seeds, runs the warm-up and collects keystream bytes for a Grain-style datapath.
// Optional macro GRAIN_CTRL_SKIDBUF_EN adds a one-byte output holding register so generation overlaps the handshake.
module grain_ctrl #(
   parameter int WARMUP = 160
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [79:0] key_in,
   input  logic [23:0] iv_in,
   input  logic [7:0]  req_len,
   input  logic        ks_bit,
   input  logic        ks_ready,
   output logic        par_load,
   output logic        shift_en,
   output logic [79:0] seed_l,
   output logic [23:0] seed_n,
   output logic [7:0]  ks_byte,
   output logic        ks_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, HOLD, DONE} state_t;

   state_t      state_q, state_d;
   logic [79:0] seed_l_q, seed_l_d;
   logic [23:0] seed_n_q, seed_n_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [7:0]  asm_q, asm_d;
   logic        ks_valid_d;
   logic        par_load_q, shift_en_q, ks_valid_q, busy_q, done_q;
`ifdef GRAIN_CTRL_SKIDBUF_EN
   logic [7:0]  hold_q, hold_d;
   logic        hold_vld_q, hold_vld_d;
   logic        asm_full_q, asm_full_d;
   logic [7:0]  gen_q, gen_d;
   logic        xfer;
`endif

   always_comb begin
      state_d  = state_q;
      seed_l_d = seed_l_q;
      seed_n_d = seed_n_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      bidx_d   = bidx_q;
      asm_d    = asm_q;
`ifdef GRAIN_CTRL_SKIDBUF_EN
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      asm_full_d = asm_full_q;
      gen_d      = gen_q;
      // cnt tracks bytes not yet handed over; gen tracks bytes not yet assembled
      xfer = hold_vld_q & ks_ready & ~abort;
      if (xfer) begin
         cnt_d      = cnt_q - 8'd1;
         hold_vld_d = 1'b0;
      end
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               seed_l_d = key_in;
               seed_n_d = iv_in;
               cnt_d    = req_len;
`ifdef GRAIN_CTRL_SKIDBUF_EN
               gen_d    = req_len;
`endif
               state_d  = LOAD;
            end
         end
         LOAD: begin
            wcnt_d  = '0;
            state_d = WARM;
         end
         WARM: begin
            if (wcnt_q == 8'(WARMUP - 1)) begin
               wcnt_d  = '0;
               bidx_d  = '0;
               state_d = (cnt_q != 8'd0) ? GEN : DONE;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         GEN: begin
            asm_d[bidx_q] = ks_bit;
            bidx_d        = bidx_q + 3'd1;
`ifdef GRAIN_CTRL_SKIDBUF_EN
            if (bidx_q == 3'd7) begin
               gen_d = gen_q - 8'd1;
               if (!hold_vld_q || xfer) begin
                  hold_d     = {ks_bit, asm_q[6:0]};
                  hold_vld_d = 1'b1;
                  state_d    = (gen_q == 8'd1) ? HOLD : GEN;
               end else begin
                  asm_full_d = 1'b1;
                  state_d    = HOLD;
               end
            end
`else
            if (bidx_q == 3'd7) state_d = HOLD;
`endif
         end
         HOLD: begin
`ifdef GRAIN_CTRL_SKIDBUF_EN
            if (xfer) begin
               if (asm_full_q) begin
                  hold_d     = asm_q;
                  hold_vld_d = 1'b1;
                  asm_full_d = 1'b0;
                  if (gen_q != 8'd0) state_d = GEN;
               end else if (cnt_q == 8'd1) begin
                  state_d = DONE;
               end
            end
`else
            if (ks_ready) begin
               cnt_d   = cnt_q - 8'd1;
               state_d = (cnt_q == 8'd1) ? DONE : GEN;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort overrides every transition, including a start seen in IDLE
      if (abort) begin
         state_d = IDLE;
         cnt_d   = cnt_q;
         wcnt_d  = '0;
         bidx_d  = '0;
`ifdef GRAIN_CTRL_SKIDBUF_EN
         hold_vld_d = 1'b0;
         asm_full_d = 1'b0;
         gen_d      = gen_q;
`endif
      end
`ifdef GRAIN_CTRL_SKIDBUF_EN
      ks_valid_d = hold_vld_d;
`else
      ks_valid_d = (state_d == HOLD);
`endif
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         seed_l_q   <= '0;
         seed_n_q   <= '0;
         cnt_q      <= '0;
         wcnt_q     <= '0;
         bidx_q     <= '0;
         asm_q      <= '0;
         par_load_q <= 1'b0;
         shift_en_q <= 1'b0;
         ks_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef GRAIN_CTRL_SKIDBUF_EN
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         asm_full_q <= 1'b0;
         gen_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         seed_l_q   <= seed_l_d;
         seed_n_q   <= seed_n_d;
         cnt_q      <= cnt_d;
         wcnt_q     <= wcnt_d;
         bidx_q     <= bidx_d;
         asm_q      <= asm_d;
         par_load_q <= (state_d == LOAD);
         shift_en_q <= (state_d == WARM) || (state_d == GEN);
         ks_valid_q <= ks_valid_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
`ifdef GRAIN_CTRL_SKIDBUF_EN
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         asm_full_q <= asm_full_d;
         gen_q      <= gen_d;
`endif
      end
   end

   // Datapath strobes drop in the very cycle abort is seen
   assign par_load = par_load_q & ~abort;
   assign shift_en = shift_en_q & ~abort;
   assign ks_valid = ks_valid_q & ~abort;
   assign done     = done_q & ~abort;
   assign busy     = busy_q;
   assign seed_l   = seed_l_q;
   assign seed_n   = seed_n_q;
`ifdef GRAIN_CTRL_SKIDBUF_EN
   assign ks_byte  = hold_q;
`else
   assign ks_byte  = asm_q;
`endif

endmodule

// File: tb/tb_grain_ctrl.sv
// Self-checking bench for grain_ctrl: exact protocol traces plus a randomized byte scoreboard.
module tb_grain_ctrl;
   localparam int WARMUP = 160;

   logic        Clk, reset, start, abort, ks_bit, ks_ready;
   logic [79:0] key_in;
   logic [23:0] iv_in;
   logic [7:0]  req_len;
   logic        par_load, shift_en, ks_valid, busy, done;
   logic [79:0] seed_l;
   logic [23:0] seed_n;
   logic [7:0]  ks_byte;
   int          n_checks = 0;
   int          n_fail   = 0;

   grain_ctrl #(.WARMUP(WARMUP)) dut (
      .Clk(Clk), .reset(reset), .start(start), .abort(abort),
      .key_in(key_in), .iv_in(iv_in), .req_len(req_len),
      .ks_bit(ks_bit), .ks_ready(ks_ready),
      .par_load(par_load), .shift_en(shift_en), .seed_l(seed_l), .seed_n(seed_n),
      .ks_byte(ks_byte), .ks_valid(ks_valid), .busy(busy), .done(done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {par_load, shift_en, ks_valid, busy, done}
   function automatic logic [4:0] outs();
      return {par_load, shift_en, ks_valid, busy, done};
   endfunction

   function automatic logic [79:0] rkey();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; ks_bit = 1'b0; ks_ready = 1'b0;
      key_in = '0; iv_in = '0; req_len = '0;
      #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", outs(), 5'b00000); end
      n_checks++;
      if ({seed_l, seed_n, ks_byte} !== 112'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {seed_l, seed_n, ks_byte}); end
      repeat (2) @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk); #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_idle: got %b want %b", outs(), 5'b00000); end
   endtask

   // Exact cycle walk of one transaction; stall<0 picks random HOLD waits
   task automatic walk_txn(input logic [79:0] k, input logic [23:0] v, input logic [7:0] len,
                           input logic [7:0] b0, input int stall);
      logic [7:0] eb;
      int st;
      @(negedge Clk); start = 1'b1; key_in = k; iv_in = v; req_len = len; ks_ready = 1'b0; #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL walk_idle: got %b want %b", outs(), 5'b00000); end
      @(negedge Clk); start = 1'b0; key_in = '0; iv_in = '0; req_len = '0; #1;
      n_checks++;
      if (outs() !== 5'b10010) begin n_fail++; $display("FAIL walk_load: got %b want %b", outs(), 5'b10010); end
      n_checks++;
      if (seed_l !== k || seed_n !== v) begin n_fail++; $display("FAIL walk_seeds: got %h/%h want %h/%h", seed_l, seed_n, k, v); end
      for (int c = 0; c < WARMUP; c++) begin
         @(negedge Clk); ks_bit = 1'($urandom); #1;
         n_checks++;
         if (outs() !== 5'b01010) begin n_fail++; $display("FAIL walk_warm cyc=%0d: got %b want %b", c, outs(), 5'b01010); end
      end
      for (int b = 0; b < int'(len); b++) begin
         eb = (b == 0) ? b0 : 8'($urandom);
         st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         for (int i = 0; i < 8; i++) begin
            @(negedge Clk); ks_bit = eb[i]; ks_ready = 1'b0; #1;
            n_checks++;
            if (outs() !== 5'b01010) begin n_fail++; $display("FAIL walk_gen byte=%0d bit=%0d: got %b want %b", b, i, outs(), 5'b01010); end
         end
         for (int j = 0; j <= st; j++) begin
            @(negedge Clk); ks_ready = (j == st); ks_bit = 1'($urandom); #1;
            n_checks++;
            if (outs() !== 5'b00110) begin n_fail++; $display("FAIL walk_hold byte=%0d cyc=%0d: got %b want %b", b, j, outs(), 5'b00110); end
            n_checks++;
            if (ks_byte !== eb) begin n_fail++; $display("FAIL walk_byte byte=%0d: got %h want %h", b, ks_byte, eb); end
         end
      end
      @(negedge Clk); ks_ready = 1'b0; #1;
      n_checks++;
      if (outs() !== 5'b00011) begin n_fail++; $display("FAIL walk_done: got %b want %b", outs(), 5'b00011); end
      @(negedge Clk); #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL walk_after: got %b want %b", outs(), 5'b00000); end
   endtask

   task automatic test_abort();
      logic [79:0] ka;
      logic [23:0] va;
      int dseen;
      ka = rkey(); va = 24'($urandom);
      @(negedge Clk); start = 1'b1; key_in = ka; iv_in = va; req_len = 8'd3; #1;
      @(negedge Clk); start = 1'b0; #1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge Clk);
         start = (c == 10); key_in = ~ka; iv_in = ~va; req_len = 8'd9; abort = (c == 50); #1;
         if (c == 50) begin
            n_checks++;
            if (outs() !== 5'b00010) begin n_fail++; $display("FAIL abort_cycle: got %b want %b", outs(), 5'b00010); end
         end
      end
      @(negedge Clk); abort = 1'b0; start = 1'b0; #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL abort_idle: got %b want %b", outs(), 5'b00000); end
      n_checks++;
      if (seed_l !== ka || seed_n !== va) begin n_fail++; $display("FAIL abort_seeds: got %h/%h want %h/%h", seed_l, seed_n, ka, va); end
      dseen = 0;
      repeat (3) begin @(negedge Clk); #1; if (done || busy) dseen++; end
      n_checks++;
      if (dseen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", dseen); end
      // start and abort together in IDLE
      @(negedge Clk); start = 1'b1; abort = 1'b1; #1;
      @(negedge Clk); start = 1'b0; abort = 1'b0; #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL start_abort_idle: got %b want %b", outs(), 5'b00000); end
      n_checks++;
      if (seed_l !== ka) begin n_fail++; $display("FAIL start_abort_seed: got %h want %h", seed_l, ka); end
   endtask

   task automatic test_reset_midwarm();
      logic [79:0] k2;
      k2 = rkey();
      @(negedge Clk); start = 1'b1; key_in = rkey(); iv_in = 24'($urandom); req_len = 8'd2; #1;
      @(negedge Clk); start = 1'b0; #1;
      repeat (30) @(negedge Clk);
      #2; reset = 1'b0; #1;
      n_checks++;
      if ({outs(), seed_l, seed_n, ks_byte} !== 117'd0) begin n_fail++; $display("FAIL midwarm_async: got %h want 0", {outs(), seed_l, seed_n, ks_byte}); end
      @(negedge Clk); #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL midwarm_held: got %b want %b", outs(), 5'b00000); end
      @(negedge Clk); reset = 1'b1; start = 1'b1; key_in = k2; iv_in = 24'h5A5A5A; req_len = 8'd1; #1;
      n_checks++;
      if (outs() !== 5'b00000) begin n_fail++; $display("FAIL release_idle: got %b want %b", outs(), 5'b00000); end
      @(negedge Clk); start = 1'b0; #1;
      n_checks++;
      if (outs() !== 5'b10010 || seed_l !== k2) begin n_fail++; $display("FAIL release_load: got %b/%h want %b/%h", outs(), seed_l, 5'b10010, k2); end
      @(negedge Clk); abort = 1'b1; #1;
      @(negedge Clk); abort = 1'b0; #1;
   endtask

`ifdef GRAIN_CTRL_SKIDBUF_EN
   task automatic test_skid_stall();
      int sh, held;
      bit fin;
      @(negedge Clk); start = 1'b1; key_in = rkey(); iv_in = 24'($urandom); req_len = 8'd3; ks_ready = 1'b0; #1;
      @(negedge Clk); start = 1'b0; #1;
      sh = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge Clk); ks_bit = 1'($urandom); #1;
         if (shift_en) sh++; else break;
      end
      n_checks++;
      if (sh !== WARMUP + 16) begin n_fail++; $display("FAIL skid_shift: got %0d want %0d", sh, WARMUP + 16); end
      n_checks++;
      if (ks_valid !== 1'b1) begin n_fail++; $display("FAIL skid_valid: got %b want 1", ks_valid); end
      held = 0;
      repeat (5) begin @(negedge Clk); #1; if (shift_en) held++; end
      n_checks++;
      if (held !== 0) begin n_fail++; $display("FAIL skid_stalled: got %0d want 0", held); end
      fin = 1'b0;
      for (int c = 0; c < 100 && !fin; c++) begin
         @(negedge Clk); ks_ready = 1'b1; #1;
         if (done) fin = 1'b1;
      end
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL skid_drain: got no done want done"); end
      @(negedge Clk); ks_ready = 1'b0; #1;
   endtask
`endif

   // Scoreboard: bits shifted after warm-up form LSB-first bytes, popped on each handshake
   task automatic test_random(input int ntx, input int fixed_len);
      for (int t = 0; t < ntx; t++) begin
         logic [7:0] len, cur, exp;
         logic [7:0] q[$];
         int nb, sh, got, ovl;
         bit fin;
         len = (fixed_len > 0) ? 8'(fixed_len) : 8'($urandom_range(1, 6));
         q.delete(); nb = 0; sh = 0; got = 0; ovl = 0; fin = 1'b0; cur = '0;
         @(negedge Clk); start = 1'b1; key_in = rkey(); iv_in = 24'($urandom); req_len = len; ks_ready = 1'b0; #1;
         for (int c = 0; c < 5000 && !fin; c++) begin
            @(negedge Clk); start = 1'b0; ks_bit = 1'($urandom); ks_ready = 1'($urandom); #1;
            if (par_load && shift_en) ovl++;
            if (shift_en) begin
               sh++;
               if (sh > WARMUP) begin
                  cur[nb] = ks_bit; nb++;
                  if (nb == 8) begin q.push_back(cur); nb = 0; end
               end
            end
            if (ks_valid && ks_ready) begin
               got++;
               n_checks++;
               if (q.size() == 0) begin
                  n_fail++; $display("FAIL rand_byte txn=%0d: got %h want none", t, ks_byte);
               end else begin
                  exp = q.pop_front();
                  if (ks_byte !== exp) begin n_fail++; $display("FAIL rand_byte txn=%0d idx=%0d: got %h want %h", t, got - 1, ks_byte, exp); end
               end
            end
            if (done) fin = 1'b1;
         end
         n_checks++;
         if (!fin) begin n_fail++; $display("FAIL rand_timeout txn=%0d: got no done want done", t); end
         n_checks++;
         if (got !== int'(len)) begin n_fail++; $display("FAIL rand_count txn=%0d: got %0d want %0d", t, got, len); end
         n_checks++;
         if (ovl !== 0) begin n_fail++; $display("FAIL rand_overlap txn=%0d: got %0d want 0", t, ovl); end
         ks_ready = 1'b0;
         @(negedge Clk); #1;
      end
   endtask

   initial begin
      test_reset();
`ifndef GRAIN_CTRL_SKIDBUF_EN
      walk_txn(80'h1, 24'h3, 8'd2, 8'h8D, 0);
      walk_txn(rkey(), 24'($urandom), 8'd2, 8'($urandom), 5);
      walk_txn(rkey(), 24'($urandom), 8'd3, 8'($urandom), -1);
`else
      test_skid_stall();
`endif
      walk_txn(rkey(), 24'($urandom), 8'd0, 8'h00, 0);
      test_abort();
      test_reset_midwarm();
      test_random(8, 0);
      test_random(1, 255);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/grain_ctrl.md
GRAIN_CTRL -- requirements
Module: grain_ctrl

Interface
REQ-001 Parameter WARMUP, default 160, is the number of warm-up shift cycles after load; legal range 1..255.
REQ-002 Port Clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Ports: start input 1 (request, sampled in IDLE); abort input 1 (synchronous cancel); key_in input 80 (LFSR seed); iv_in input 24 (NFSR seed); req_len input 8 (keystream bytes requested).
REQ-005 Ports: ks_bit input 1 (keystream bit from the cipher datapath); ks_ready input 1 (consumer accepts the byte).
REQ-006 Ports: par_load output 1 and shift_en output 1 (datapath controls); seed_l output 80 and seed_n output 24 (registered seeds to the datapath).
REQ-007 Ports: ks_byte output 8; ks_valid output 1; busy output 1; done output 1.

Function
REQ-008 The FSM states SHALL be IDLE, LOAD, WARM, GEN, HOLD, DONE; busy = 1 in every state except IDLE.
REQ-009 IDLE: when start=1, the block SHALL capture key_in into seed_l, iv_in into seed_n and req_len into a byte counter, then go to LOAD; otherwise it stays in IDLE.
REQ-010 LOAD lasts exactly one cycle with par_load=1 and shift_en=0, then goes to WARM.
REQ-011 WARM: shift_en=1 for exactly WARMUP consecutive cycles, with ks_bit ignored.
- After WARM: GEN if the byte counter is nonzero, else DONE.
REQ-012 GEN: shift_en=1.
- ks_bit is sampled in each GEN cycle.
- The i-th sampled bit (i=0..7) goes to ks_byte[i] (LSB-first).
- After the 8th bit, go to HOLD.
REQ-013 HOLD: shift_en=0 and ks_valid=1, with ks_byte stable.
- A transfer occurs on a cycle with ks_valid=1 and ks_ready=1.
- On transfer, decrement the byte counter; go to GEN if the result is nonzero, else DONE.
REQ-014 DONE lasts one cycle with done=1, then goes to IDLE; done is 0 in every other state.
REQ-015 par_load and shift_en SHALL never both be 1.
REQ-016 start while busy=1 SHALL be ignored, and the captured seeds and length stay unchanged.
REQ-017 abort=1 in any busy state SHALL force IDLE on the next edge.
- During that abort cycle, shift_en, par_load and ks_valid are 0.
- done is not asserted.
- abort has priority over every other transition.
REQ-018 Simultaneous start and abort in IDLE: abort wins, and the block stays in IDLE.
REQ-019 req_len=255 SHALL produce 255 bytes; the counter does not wrap.

Reset
REQ-020 While reset=0, the block SHALL immediately enter IDLE, asynchronously, including mid-operation.
REQ-021 The reset value of every output and register is 0: par_load, shift_en, seed_l, seed_n, ks_byte, ks_valid, busy, done, the bit index, the warm-up counter and the byte counter.
REQ-022 The first edge after reset deasserts SHALL be an ordinary IDLE cycle.

Configuration
REQ-023 Macro GRAIN_CTRL_SKIDBUF_EN.
- When defined, a one-byte output holding register SHALL let GEN keep shifting while a previous byte waits in HOLD.
- Shifting stalls (shift_en=0) only when the holding register is full and a new byte completes.
- When undefined, behaviour is exactly REQ-012/REQ-013: no shifting while ks_valid=1.
- Byte order and count are identical in both builds.

Verification
REQ-024 Reset mid-WARM: assert reset=0 asynchronously -> all outputs 0 before the next edge; the block is in IDLE after release.
REQ-025 start, key=80'h1, iv=24'h3, len=2, WARMUP=160, ks_ready=1 -> seeds latched; one par_load cycle; 160 shift_en cycles; 8 GEN cycles; ks_valid; 8 GEN cycles; ks_valid; one done pulse; busy low afterwards.
REQ-026 ks_bit driven 1,0,1,1,0,0,0,1 over GEN cycles -> ks_byte=8'h8D.
REQ-027 Macro undefined, ks_ready held 0 for 5 cycles in HOLD -> shift_en=0 and ks_byte stable throughout; transfer on the 6th cycle.
- Macro defined, same stimulus -> shifting continues until the second byte completes, then stalls.
REQ-028 abort on WARM cycle 50 -> IDLE next edge, no done; a second start during WARM has no effect on the captured seeds.
REQ-029 start with len=0 -> LOAD, 160 WARM cycles, DONE; ks_valid never asserted.
